// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared types and constants for the LM/SM sequencer
package lmsm_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREG = 8;
  localparam int IDX_W = 3;
  localparam logic RWBAR_READ = 1'b1;
  localparam logic RWBAR_WRITE = 1'b0;
endpackage

// File: rtl/lmsm_prio_enc.sv
// lmsm_prio_enc: lowest-set-bit encoder
// ports: v (request mask) -> idx (lowest set bit index), valid (any bit set)
module lmsm_prio_enc import lmsm_pkg::*; #(
  parameter int NREG = DEF_NREG
) (
  input  logic [NREG-1:0]  v,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (v[i]) idx = IDX_W'(i);
  end
  assign valid = |v;
endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: multi-cycle Load-Multiple / Store-Multiple sequencer
// inputs : clk, resetn (async, active-low), flush, start, is_store, base_addr, reg_list,
//          mem_rdata (async memory read data), rf_rd_data (combinational RF read data)
// outputs: mem_addr, rwbar, mem_wdata, rf_rd_idx, rf_wr_en, rf_wr_idx, rf_wr_data,
//          stall, busy, done
// option : LMSM_ADDR_WB_EN adds addr_wb_en / addr_wb_data for base-register writeback
module lmsm_sequencer import lmsm_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG = DEF_NREG
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_list,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rwbar,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  rf_rd_idx,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_idx,
  output logic [DATA_W-1:0] rf_wr_data,
`ifdef LMSM_ADDR_WB_EN
  output logic              addr_wb_en,
  output logic [ADDR_W-1:0] addr_wb_data,
`endif
  output logic              stall,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic [NREG-1:0] mask, nmask;
  logic [ADDR_W-1:0] addr;
  logic st, valid, acc, sm, lm;
  logic [IDX_W-1:0] idx;
  lmsm_prio_enc #(.NREG(NREG)) u_enc (.v(mask), .idx(idx), .valid(valid));
  // clearing the lowest set bit is the same bit the encoder selected
  assign nmask = mask & (mask - NREG'(1));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      mask <= '0;
      addr <= '0;
      st <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      mask <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          mask <= reg_list;
          addr <= base_addr;
          st <= is_store;
          state <= |reg_list ? ACCESS : DONE;
        end
        ACCESS: begin
          mask <= nmask;
          addr <= addr + ADDR_W'(1);
          state <= |nmask ? ACCESS : DONE;
        end
        default: state <= IDLE;
      endcase
  assign acc = state == ACCESS && valid;
  assign sm = acc && st;
  assign lm = acc && !st;
  assign mem_addr = acc ? addr : '0;
  assign rwbar = (sm && !flush) ? RWBAR_WRITE : RWBAR_READ;
  assign mem_wdata = sm ? rf_rd_data : '0;
  assign rf_rd_idx = sm ? idx : '0;
  assign rf_wr_en = lm && !flush;
  assign rf_wr_idx = lm ? idx : '0;
  assign rf_wr_data = lm ? mem_rdata : '0;
  // stall rises in the accepting cycle so the pipeline freezes before the first access
  assign stall = acc || (state == IDLE && start && !flush && |reg_list);
  assign busy = state != IDLE;
  assign done = state == DONE && !flush;
`ifdef LMSM_ADDR_WB_EN
  // addr has advanced once per access, so in DONE it holds base + popcount(list)
  assign addr_wb_en = done;
  assign addr_wb_data = done ? addr : '0;
`endif
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed self-checking bench for lmsm_sequencer
module tb_lmsm_sequencer;
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, start = 1'b0, is_store = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0] reg_list = '0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rf_rd_data, rf_wr_data;
  logic rwbar, rf_wr_en, stall, busy, done;
  logic [2:0] rf_rd_idx, rf_wr_idx;
`ifdef LMSM_ADDR_WB_EN
  logic addr_wb_en;
  logic [15:0] addr_wb_data;
`endif
  int n_chk = 0, n_fail = 0;
  logic [15:0] t1_a [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
  logic [2:0] t1_i [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
  logic [15:0] t1_d [4] = '{16'hAABA, 16'hAABB, 16'hAAB8, 16'hAAB9};
  logic [15:0] t4_a [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
  logic [15:0] t4_d [3] = '{16'h5554, 16'h5555, 16'hAAAA};
  always #5 clk = ~clk;
  assign mem_rdata = mem_addr ^ 16'hAAAA;
  assign rf_rd_data = 16'hC000 | {13'd0, rf_rd_idx};
  lmsm_sequencer dut (
    .clk(clk), .resetn(resetn), .flush(flush), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_list(reg_list), .mem_addr(mem_addr), .rwbar(rwbar),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rf_rd_idx(rf_rd_idx),
    .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
    .rf_wr_data(rf_wr_data),
`ifdef LMSM_ADDR_WB_EN
    .addr_wb_en(addr_wb_en), .addr_wb_data(addr_wb_data),
`endif
    .stall(stall), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_rwbar"}, rwbar, 1);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdidx"}, rf_rd_idx, 0);
    chk({tag, "_wren"}, rf_wr_en, 0);
    chk({tag, "_wridx"}, rf_wr_idx, 0);
    chk({tag, "_wrdata"}, rf_wr_data, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  initial begin
    #2;
    idle_chk("rst");
`ifdef LMSM_ADDR_WB_EN
    chk("rst_wb_en", addr_wb_en, 0);
`endif
    tick; resetn = 1'b1;
    tick; #1 idle_chk("idle");
    // LM 0x0010, list 1010_0101
    tick; start = 1; is_store = 0; base_addr = 16'h0010; reg_list = 8'hA5;
    #1 chk("t1_acc_stall", stall, 1); chk("t1_acc_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick; start = 0;
      #1 chk("t1_addr", mem_addr, t1_a[k]);
      chk("t1_rwbar", rwbar, 1);
      chk("t1_wren", rf_wr_en, 1);
      chk("t1_wridx", rf_wr_idx, t1_i[k]);
      chk("t1_wrdata", rf_wr_data, t1_d[k]);
      chk("t1_stall", stall, 1);
      chk("t1_done", done, 0);
    end
    tick; #1 chk("t1_done5", done, 1); chk("t1_stall5", stall, 0); chk("t1_busy5", busy, 1);
    chk("t1_wren5", rf_wr_en, 0);
`ifdef LMSM_ADDR_WB_EN
    chk("t1_wb_en", addr_wb_en, 1); chk("t1_wb_data", addr_wb_data, 16'h0014);
`endif
    tick; #1 chk("t1_done6", done, 0); chk("t1_busy6", busy, 0);
    // SM 0x0100, all registers; a start mid-sequence is ignored
    tick; start = 1; is_store = 1; base_addr = 16'h0100; reg_list = 8'hFF;
    #1 chk("t2_acc_stall", stall, 1);
    for (int k = 0; k < 8; k++) begin
      tick; start = (k == 3); is_store = 0; reg_list = 8'h00; base_addr = 16'h0555;
      #1 chk("t2_rwbar", rwbar, 0);
      chk("t2_rdidx", rf_rd_idx, k);
      chk("t2_addr", mem_addr, 16'h0100 + k);
      chk("t2_wdata", mem_wdata, 16'hC000 + k);
      chk("t2_wren", rf_wr_en, 0);
      chk("t2_stall", stall, 1);
    end
    tick; start = 0; #1 chk("t2_done9", done, 1); chk("t2_rwbar9", rwbar, 1);
    tick; #1 chk("t2_done10", done, 0); chk("t2_busy10", busy, 0);
    // empty list
    tick; start = 1; is_store = 0; base_addr = 16'h0040; reg_list = 8'h00;
    #1 chk("t3_stall0", stall, 0);
    tick; start = 0;
    #1 chk("t3_done1", done, 1); chk("t3_busy1", busy, 1); chk("t3_stall1", stall, 0);
    chk("t3_rwbar1", rwbar, 1); chk("t3_wren1", rf_wr_en, 0);
`ifdef LMSM_ADDR_WB_EN
    chk("t3_wb_data", addr_wb_data, 16'h0040);
`endif
    tick; #1 chk("t3_done2", done, 0); chk("t3_busy2", busy, 0);
    // address wrap
    tick; start = 1; is_store = 0; base_addr = 16'hFFFE; reg_list = 8'h07;
    for (int k = 0; k < 3; k++) begin
      tick; start = 0;
      #1 chk("t4_addr", mem_addr, t4_a[k]);
      chk("t4_wridx", rf_wr_idx, k);
      chk("t4_wrdata", rf_wr_data, t4_d[k]);
      chk("t4_wren", rf_wr_en, 1);
    end
    tick; #1 chk("t4_done", done, 1);
`ifdef LMSM_ADDR_WB_EN
    chk("t4_wb_en", addr_wb_en, 1); chk("t4_wb_data", addr_wb_data, 16'h0001);
`endif
    tick; #1 chk("t4_busy", busy, 0);
    // flush in 2nd access, with a start in the same cycle
    tick; start = 1; is_store = 0; base_addr = 16'h0020; reg_list = 8'h0F;
    tick; start = 0; #1 chk("t5_wren1", rf_wr_en, 1); chk("t5_wridx1", rf_wr_idx, 0);
    tick; flush = 1; start = 1;
    #1 chk("t5_wren2", rf_wr_en, 0); chk("t5_rwbar2", rwbar, 1); chk("t5_done2", done, 0);
    tick; flush = 0; start = 0;
    #1 chk("t5_busy3", busy, 0); chk("t5_stall3", stall, 0);
    for (int k = 0; k < 3; k++) begin
      tick; #1 chk("t5_nodone", done, 0); chk("t5_idle", busy, 0);
    end
    // start with flush while idle
    tick; flush = 1; start = 1; is_store = 1; reg_list = 8'h01;
    #1 chk("t5_fs_stall", stall, 0);
    tick; flush = 0; start = 0; #1 chk("t5_fs_busy", busy, 0); chk("t5_fs_rwbar", rwbar, 1);
    // reset mid SM
    tick; start = 1; is_store = 1; base_addr = 16'h0200; reg_list = 8'hF0;
    tick; start = 0; #1 chk("t6_rdidx1", rf_rd_idx, 4); chk("t6_addr1", mem_addr, 16'h0200);
    tick; #1 chk("t6_rwbar2", rwbar, 0); chk("t6_rdidx2", rf_rd_idx, 5);
    #1 resetn = 0;
    #1 chk("t6_rst_rwbar", rwbar, 1); chk("t6_rst_stall", stall, 0);
    chk("t6_rst_busy", busy, 0); chk("t6_rst_addr", mem_addr, 0);
    tick; resetn = 1;
    tick; start = 1; is_store = 0; base_addr = 16'h0030; reg_list = 8'h03;
    tick; start = 0; #1 chk("t6_a0", mem_addr, 16'h0030); chk("t6_w0", rf_wr_data, 16'hAA9A);
    tick; #1 chk("t6_a1", mem_addr, 16'h0031); chk("t6_i1", rf_wr_idx, 1);
    tick; #1 chk("t6_done", done, 1);
    tick; #1 idle_chk("end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
